// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: operation codes,
// memory stage tag, FSM state type and small decode helpers.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    localparam logic [2:0] MEM_STAGE = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } state_t;

    // Loads occupy the low five encodings.
    function automatic logic is_load(input logic [2:0] op);
        return op <= OP_LHU;
    endfunction

    // Word accesses need 4-byte alignment, halfword accesses 2-byte alignment.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte/halfword lane handling: load lane select with sign/zero extension, and
// store lane merge into the word read back from memory (little-endian lanes).
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lane out of the read word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        load_data = rdata;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store lane onto the read word for the write-back half of RMW.
    always_comb begin
        merged = rdata;
        case (op)
            OP_SB: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = rdata;
                endcase
            end
            OP_SH: begin
                if (addr_lo[1]) merged[31:16] = wdata;
                else            merged[15:0]  = wdata;
            end
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator between execute and the word-wide memory. Adds
// sub-word loads, read-modify-write sub-word stores and fault detection.
//
// state | meaning
// IDLE  | ready; accepting a request
// RD    | memRead strobe, memory captures outvalue at end of cycle
// CAP   | outvalue valid; format load data or build merge word
// WR    | memWrite strobe with full word
// DONE  | one-cycle response pulse
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int WORD_AW   = 8,
    parameter int MEM_WORDS = 128
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_fault,
    output logic               memRead,
    output logic               memWrite,
    output logic [WORD_AW-1:0] memaddress,
    output logic [31:0]        invalue,
    input  logic [31:0]        outvalue,
    output logic [2:0]         mem_stage
);

    localparam int AB = WORD_AW + 2;
    localparam logic [WORD_AW:0] WORDS_LIM = MEM_WORDS[WORD_AW:0];

    state_t        state, state_nxt;
    logic [AB-1:0] addr_q;
    logic [2:0]    op_q;
    logic [31:0]   wdata_q, merge_q, rdata_q;
    logic          fault_q;
    logic          accept, fault_now;
    logic [31:0]   load_data, merged;
    logic          unused_addr_hi;

    // Address bits above the word index do not select memory.
    assign unused_addr_hi = ^req_addr[31:AB];

    assign accept    = (state == ST_IDLE) && req_valid;
    assign fault_now = misaligned(req_op, req_addr[1:0]) ||
                       ({1'b0, req_addr[AB-1:2]} >= WORDS_LIM);

    assign memaddress = addr_q[AB-1:2];
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q && (state == ST_DONE);

    mem_lane_fmt u_lane_fmt (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .rdata     (outvalue),
        .wdata     (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and strobe/handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        mem_stage  = 3'd0;
        invalue    = 32'h0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault_now)             state_nxt = ST_DONE;
                    else if (req_op == OP_SW)  state_nxt = ST_WR;
                    else                       state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                memRead   = 1'b1;
                mem_stage = MEM_STAGE;
                state_nxt = ST_CAP;
            end
            ST_CAP: begin
                state_nxt = is_load(op_q) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                memWrite  = 1'b1;
                mem_stage = MEM_STAGE;
                invalue   = (op_q == OP_SW) ? wdata_q : merge_q;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on accept, load result / merge word capture in CAP.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q  <= '0;
            op_q    <= OP_LW;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr[AB-1:0];
            op_q    <= req_op;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            fault_q <= fault_now;
        end else if (state == ST_CAP) begin
            if (is_load(op_q)) rdata_q <= load_data;
            else               merge_q <= merged;
        end
    end

endmodule
